// File: rtl/gs_pkg.sv
// Shared widths, saturation constant and FSM state encoding for the
// Gauss-Seidel reciprocal dispatch slice.
package gs_pkg;

  localparam int GS_DW = 8;
  localparam int GS_QW = 32;
  localparam logic [31:0] RCP_SAT = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_STORE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/recip_regfile.sv
// N x QW result store: synchronous write, asynchronous read, synchronous clear.
// A same-cycle write and read of one entry returns the old contents.
module recip_regfile
  import gs_pkg::*;
#(
  parameter int N  = 16,
  parameter int QW = GS_QW,
  parameter int AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [QW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [QW-1:0] o_rdata
);

  logic [QW-1:0] mem_q [N];
  logic [QW-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (i_we) mem_d[i_waddr] = i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/recip_dispatch.sv
// Initiator side of the reciprocal-unit handshake: one clear+request per coefficient,
// results stored by index. Optional watchdog enabled by macro RCP_TIMEOUT_EN.
module recip_dispatch
  import gs_pkg::*;
#(
  parameter int N_COEF  = 16,
  parameter int DW      = GS_DW,
  parameter int QW      = GS_QW,
  parameter int TIMEOUT = 63,
  localparam int AW     = $clog2(N_COEF)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_coef_valid,
  output logic                 o_coef_ready,
  input  logic signed [DW-1:0] i_coef,
  output logic                 o_rcp_reset,
  output logic                 o_rcp_valid,
  output logic signed [DW-1:0] o_rcp_divisor,
  input  logic                 i_rcp_valid,
  input  logic        [QW-1:0] i_rcp_quotient,
  input  logic        [AW-1:0] i_rd_addr,
  output logic        [QW-1:0] o_rd_data,
  output logic                 o_done,
`ifdef RCP_TIMEOUT_EN
  output logic                 o_tmo_err,
`endif
  output logic                 o_zero_err
);

  localparam logic [QW-1:0] SAT      = QW'(RCP_SAT);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_COEF - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic signed [DW-1:0]  div_q, div_d;
  logic [QW-1:0]         data_q, data_d;
  logic                  zero_q, zero_d;
  logic                  wr_en;
`ifdef RCP_TIMEOUT_EN
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);
  logic [5:0]            wdog_q, wdog_d;
  logic                  tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    data_d  = data_q;
    zero_d  = zero_q;
    wr_en   = 1'b0;
`ifdef RCP_TIMEOUT_EN
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_coef_valid) begin
          div_d = i_coef;
          // A zero divisor never reaches the unit; saturate directly.
          if (i_coef == '0) begin
            data_d  = SAT;
            zero_d  = 1'b1;
            state_d = ST_STORE;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_ISSUE;
`ifdef RCP_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      ST_ISSUE: begin
        if (i_rcp_valid) begin
          data_d  = i_rcp_quotient;
          state_d = ST_STORE;
        end
`ifdef RCP_TIMEOUT_EN
        else if (wdog_q == TMO_LAST) begin
          data_d  = SAT;
          tmo_d   = 1'b1;
          state_d = ST_STORE;
        end else begin
          wdog_d  = wdog_q + 6'd1;
        end
`endif
      end
      ST_STORE: begin
        wr_en   = 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      zero_q  <= 1'b0;
`ifdef RCP_TIMEOUT_EN
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      zero_q  <= zero_d;
`ifdef RCP_TIMEOUT_EN
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Captured result needs no reset: it is only written to the regfile from STORE.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
  end

  // Outputs are gated by i_reset so an abort takes effect in the same cycle.
  assign o_coef_ready  = (state_q == ST_IDLE)  && !i_reset;
  assign o_rcp_reset   = (state_q == ST_CLEAR) ||  i_reset;
  assign o_rcp_valid   = (state_q == ST_ISSUE) && !i_reset;
  assign o_rcp_divisor = i_reset ? '0 : div_q;
  assign o_done        = (state_q == ST_DONE)  && !i_reset;
  assign o_zero_err    = zero_q && !i_reset;
`ifdef RCP_TIMEOUT_EN
  assign o_tmo_err     = tmo_q && !i_reset;
`endif

  recip_regfile #(
    .N  (N_COEF),
    .QW (QW),
    .AW (AW)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_clr   (i_reset),
    .i_we    (wr_en),
    .i_waddr (idx_q),
    .i_wdata (data_q),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

endmodule
